// File: rtl/spi_src_arbiter_if.sv
// Shared SPI data-bus arbitration signals between the requesters/shifter and the arbiter.
interface spi_src_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       xfer_done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

  // Requester/shifter side
  modport master (
    output req,
    output last,
    output xfer_done,
    input  sel,
    input  grant,
    input  busy
  );

  // Arbiter side
  modport slave (
    input  req,
    input  last,
    input  xfer_done,
    output sel,
    output grant,
    output busy
  );
endinterface

// File: rtl/spi_src_arbiter.sv
// Four-way round-robin arbiter for a shared SPI data bus with burst limiting.
// A grant lasts until the owner's last byte, MAX_BURST bytes, or the owner drops req;
// every release is followed by at least one idle (turnaround) cycle.
module spi_src_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_src_arbiter_if.slave  bus
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;     // doubles as the owner index while owned
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic       any_req;
  logic [1:0] winner;
  logic [7:0] cnt_inc;
  logic       release_now;

  // Rotating-priority search: lowest offset from ptr wins (scan high to low, last hit wins)
  always_comb begin
    any_req = |bus.req;
    winner  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
      end
    end
  end

  // Release on abort, on the owner's final byte, or when the burst limit is reached
  always_comb begin
    cnt_inc     = cnt_q + 8'd1;
    release_now = !bus.req[sel_q] ||
                  (bus.xfer_done && (bus.last[sel_q] || (cnt_inc == MaxBurst)));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // xfer_done is ignored here; sel holds until a new grant
        if (any_req) begin
          state_d = StOwned;
          sel_d   = winner;
          cnt_d   = 8'd0;
        end
      end
      StOwned: begin
        if (bus.xfer_done) begin
          cnt_d = cnt_inc;
        end
        if (release_now) begin
          state_d = StIdle;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded straight from registered state
  always_comb begin
    bus.sel   = sel_q;
    bus.busy  = (state_q == StOwned);
    bus.grant = (state_q == StOwned) ? (4'b0001 << sel_q) : 4'b0000;
  end

endmodule
